demux_1to3_buffered: RTL
========================

# demux_1to3_buffered

One-to-three routing block: the counterpart of the datapath's 2/3-input selectors. It accepts a single 32-bit value with a 2-bit destination select and delivers it to one of three output channels. Each channel has a one-entry holding register with a valid/ready handshake. Used where one producer (e.g. a write-back result) feeds several independent consumers that may stall; illegal selects are dropped and counted.

## Interface
- WIDTH, 32, data width of input and all output channels
- CNT_W, 8, width of the saturating drop counter
- clk  input  1  rising-edge clock; sole clock domain
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  value to route
- in_select  input  2  destination: 2'b00 → ch0, 2'b01 → ch1, 2'b10 → ch2, 2'b11 illegal
- in_valid  input  1  in_data/in_select valid this cycle
- in_ready  output  1  block accepts the input this cycle (combinational)
- out_data_0/1/2  output  WIDTH  holding-register contents per channel
- out_valid_0/1/2  output  1  channel holds an undelivered value
- out_ready_0/1/2  input  1  consumer takes the value this cycle
- drop_pulse  output  1  one-cycle pulse: an illegal-select transfer was discarded
- drop_count  output  CNT_W  number of discarded transfers, saturating

## Operation
- Transfer in: in_valid && in_ready at a clock edge. Transfer out on channel k: out_valid_k && out_ready_k.
- in_ready: for select k in 0..2, in_ready = !out_valid_k || out_ready_k. For select 2'b11, in_ready = 1. Depends only on the selected channel; other channels never stall the input.
- On accept with legal select k: out_data_k ← in_data and out_valid_k ← 1 at the same edge. Other channels are unchanged.
- On out-transfer on k with no refill: out_valid_k ← 0. out_data_k holds its last value.
- Simultaneous drain and refill of k: out_valid_k stays 1 and out_data_k takes the new value. No bubble, no loss.
- Valid held with ready low: out_data_k and out_valid_k remain stable until taken.
- Illegal select accepted: no channel changes; drop_pulse ← 1 for exactly one cycle. drop_count increments by 1 and saturates at 2^CNT_W−1; it does not wrap.
- Back-to-back illegal accepts: drop_pulse stays high on each following cycle, and the count increments each cycle.
- in_valid low: in_ready still driven per the rules above; nothing is latched.
- in_select is sampled only on accept.

## Timing
- Latency: value is visible on out_data_k / out_valid_k one cycle after the accepting edge.
- Throughput: one transfer per cycle per channel when the consumer keeps ready high. Alternating destinations also sustain one transfer per cycle.
- in_ready is combinational from in_select and out_ready_k / out_valid_k. It has no path from in_valid.
- drop_pulse is registered and asserts in the cycle after the accepting edge.
- Reset (synchronous, dominates all other events): all out_valid_k = 0, all out_data_k = 0, drop_pulse = 0, drop_count = 0.
- Reset during operation: held values are discarded without being delivered.
- An input presented in the reset cycle is not accepted. in_ready may still evaluate to 1 during reset; this is ignored.

## Test plan
- Reset then route: assert rst for 2 cycles, then send 0xDEADBEEF with select 2'b01. Required: out_valid_1 = 1 and out_data_1 = 0xDEADBEEF one cycle later; ch0 and ch2 stay invalid with data 0.
- Stall and hold: set out_ready_0 = 0 and send 0x11111111 to ch0, then present 0x22222222 to ch0. Required: in_ready = 0 and out_data_0 stays 0x11111111. Raise out_ready_0: 0x11111111 is consumed and 0x22222222 appears the next cycle.
- Independence: hold ch0 full and stalled, then send 0xA5A5A5A5 to ch2. Required: in_ready = 1, ch2 delivers the value, and ch0 is unchanged.
- Streaming: out_ready_1 = 1 continuously; send values 1..8 to ch1 on consecutive cycles. Required: in_ready stays 1 and out_data_1 shows 1..8 on consecutive cycles with out_valid_1 = 1 throughout.
- Illegal select: send 3 transfers with select 2'b11 back-to-back. Required: in_ready = 1, drop_pulse high for 3 cycles, drop_count = 3, and no channel changes. Preload the count to 254 and send 3 more. Required: drop_count = 255.
- Reset mid-operation: fill all three channels with ready low, then assert rst for 1 cycle. Required: all out_valid = 0, all data = 0, drop_count = 0 on the next cycle.

Source files
------------

// File: rtl/demux_1to3_buffered.sv
// demux_1to3_buffered: routes one input to one of three single-entry valid/ready channels, dropping and counting illegal selects.
module demux_1to3_buffered #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data_0,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2,
  output logic             out_valid_0,
  output logic             out_valid_1,
  output logic             out_valid_2,
  input  logic             out_ready_0,
  input  logic             out_ready_1,
  input  logic             out_ready_2,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_count
);
  logic [WIDTH-1:0] data_q [3];
  logic [WIDTH-1:0] data_d [3];
  logic [2:0]       valid_q, valid_d, out_ready;
  logic [3:0]       rdy_sel;
  logic             accept, drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  assign out_ready = {out_ready_2, out_ready_1, out_ready_0};
  // Select 3 always accepts so an illegal request can never stall the producer.
  assign rdy_sel  = {1'b1, ~valid_q | out_ready};
  assign in_ready = rdy_sel[in_select];
  assign accept   = in_valid && in_ready;
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q & ~out_ready;
    drop_pulse_d = accept && (in_select == 2'b11);
    drop_count_d = (drop_pulse_d && !(&drop_count_q)) ? drop_count_q + 1'b1 : drop_count_q;
    for (int k = 0; k < 3; k++) begin
      if (accept && in_select == 2'(k)) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      data_q       <= '{default: '0};
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end
  assign out_data_0  = data_q[0];
  assign out_data_1  = data_q[1];
  assign out_data_2  = data_q[2];
  assign out_valid_0 = valid_q[0];
  assign out_valid_1 = valid_q[1];
  assign out_valid_2 = valid_q[2];
  assign drop_pulse  = drop_pulse_q;
  assign drop_count  = drop_count_q;
endmodule
